// File: rtl/mcht_enc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mcht_pkg
// Purpose : Shared types and constants for the Manchester encoder family
//           (encoder state enum, polarity constants, idle line level and a
//           helper that maps a data bit to its half-bit line level).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mcht_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE_LO = 3'd1,
    PRE_HI = 3'd2,
    BIT_A  = 3'd3,
    BIT_B  = 3'd4,
    STOP   = 3'd5
  } t_mcht_st;

  localparam logic cPOL_LEGACY = 1'b0;  // bit b sent as (~b, b)
  localparam logic cPOL_IEEE   = 1'b1;  // bit b sent as (b, ~b)
  localparam logic cTXD_IDLE   = 1'b1;

  // Line level for one half of a data bit; second=1 selects the second half.
  function automatic logic slot_level(input logic b, input logic pol, input logic second);
    return (pol == cPOL_IEEE) ? (b ^ second) : (~b ^ second);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcht_enc_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : mcht_enc_gen_if
// Purpose : Request/status bundle between the message-building controller
//           (master) and the Manchester encoder (slave).
// Ports   : START/MSG/LEN/MSB_FIRST/POL/ABORT  master -> slave
//           RDY/BUSY/DONE/TXD                  slave  -> master
// Revision: 1.0 - initial release
// ============================================================================
interface mcht_enc_gen_if #(
  parameter int pMSG_LEN = 16
);
  localparam int cLEN_W = $clog2(pMSG_LEN + 1);

  logic                START;
  logic                RDY;
  logic [pMSG_LEN-1:0] MSG;
  logic [cLEN_W-1:0]   LEN;
  logic                MSB_FIRST;
  logic                POL;
  logic                ABORT;
  logic                BUSY;
  logic                DONE;
  logic                TXD;

  modport master (
    output START, MSG, LEN, MSB_FIRST, POL, ABORT,
    input  RDY, BUSY, DONE, TXD
  );

  modport slave (
    input  START, MSG, LEN, MSB_FIRST, POL, ABORT,
    output RDY, BUSY, DONE, TXD
  );
endinterface
`default_nettype wire

// File: rtl/mcht_half_tmr.sv
`default_nettype none
// ============================================================================
// Module  : mcht_half_tmr
// Purpose : Half-bit slot timer. Counts 0..pHALF_CYC-1 and flags the last
//           cycle of each slot; wraps to 0 by itself on expiry.
// Ports   : clk     in  clock
//           rst_n   in  asynchronous active-low reset
//           clr     in  hold the count at 0
//           expire  out high on the last cycle of a slot
// Revision: 1.0 - initial release
// ============================================================================
module mcht_half_tmr #(
  parameter int pHALF_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic expire
);
  localparam int cW = (pHALF_CYC > 1) ? $clog2(pHALF_CYC) : 1;
  localparam logic [cW-1:0] cLAST = cW'(pHALF_CYC - 1);

  logic [cW-1:0] cnt_q;
  logic [cW-1:0] cnt_d;

  assign expire = (cnt_q == cLAST);

  always_comb begin
    cnt_d = cnt_q + cW'(1);
    if (clr || expire) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule
`default_nettype wire

// File: rtl/mcht_enc_gen.sv
`default_nettype none
// ============================================================================
// Module  : mcht_enc_gen
// Purpose : Parametrised Manchester frame encoder: preamble pairs, L data
//           bits (two slots each, selectable order/polarity), one stop slot.
// Ports   : CLK_25M  in  system clock
//           RST_N    in  asynchronous active-low reset
//           enc      slave side of mcht_enc_gen_if (START/RDY handshake,
//                    MSG/LEN/MSB_FIRST/POL captured at accept, ABORT,
//                    BUSY, DONE pulse, TXD line)
// Revision: 1.0 - initial release
// ============================================================================
module mcht_enc_gen
  import mcht_pkg::*;
#(
  parameter int pMSG_LEN  = 16,
  parameter int pHALF_CYC = 1,
  parameter int pPRE_LEN  = 1
) (
  input  logic           CLK_25M,
  input  logic           RST_N,
  mcht_enc_gen_if.slave  enc
);
  localparam int cLEN_W = $clog2(pMSG_LEN + 1);
  localparam int cPRE_W = $clog2(pPRE_LEN + 1);
  localparam logic [cLEN_W-1:0] cLEN_MAX = cLEN_W'(pMSG_LEN);
  localparam logic [cPRE_W-1:0] cPRE_NUM = cPRE_W'(pPRE_LEN);

  t_mcht_st            state_q,     state_d;
  logic [pMSG_LEN-1:0] sr_q,        sr_d;
  logic [cLEN_W-1:0]   bit_cnt_q,   bit_cnt_d;
  logic [cPRE_W-1:0]   pre_cnt_q,   pre_cnt_d;
  logic                msb_first_q, msb_first_d;
  logic                pol_q,       pol_d;
  logic                txd_q,       txd_d;
  logic                rdy_q,       rdy_d;
  logic                done_q,      done_d;

  logic                tmr_exp;
  logic                tmr_clr;
  logic [cLEN_W-1:0]   len_eff;
  logic                next_bit;

  assign len_eff = ((enc.LEN == '0) || (enc.LEN > cLEN_MAX)) ? cLEN_MAX : enc.LEN;
  // Timer is held at 0 while idle so the first slot is always a full H cycles.
  assign tmr_clr = (state_q == IDLE);

  mcht_half_tmr #(.pHALF_CYC(pHALF_CYC)) u_tmr (
    .clk    (CLK_25M),
    .rst_n  (RST_N),
    .clr    (tmr_clr),
    .expire (tmr_exp)
  );

  // State register
  always_ff @(posedge CLK_25M or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      pre_cnt_q   <= '0;
      msb_first_q <= 1'b0;
      pol_q       <= cPOL_LEGACY;
      txd_q       <= cTXD_IDLE;
      rdy_q       <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      msb_first_q <= msb_first_d;
      pol_q       <= pol_d;
      txd_q       <= txd_d;
      rdy_q       <= rdy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    msb_first_d = msb_first_q;
    pol_d       = pol_q;
    case (state_q)
      IDLE: begin
        // ABORT is ignored here, so START always wins in IDLE.
        if (enc.START) begin
          state_d     = PRE_LO;
          // MSB-first: left-justify so bit L-1 lands in the MSB.
          sr_d        = enc.MSB_FIRST ? (enc.MSG << (cLEN_MAX - len_eff)) : enc.MSG;
          bit_cnt_d   = len_eff;
          pre_cnt_d   = cPRE_NUM;
          msb_first_d = enc.MSB_FIRST;
          pol_d       = enc.POL;
        end
      end
      PRE_LO, PRE_HI, BIT_A, BIT_B, STOP: begin
        if (enc.ABORT) begin
          state_d = IDLE;
        end else if (tmr_exp) begin
          case (state_q)
            PRE_LO: state_d = PRE_HI;
            PRE_HI: begin
              pre_cnt_d = pre_cnt_q - cPRE_W'(1);
              state_d   = (pre_cnt_q == cPRE_W'(1)) ? BIT_A : PRE_LO;
            end
            BIT_A:  state_d = BIT_B;
            BIT_B: begin
              bit_cnt_d = bit_cnt_q - cLEN_W'(1);
              sr_d      = msb_first_q ? (sr_q << 1) : (sr_q >> 1);
              state_d   = (bit_cnt_q == cLEN_W'(1)) ? STOP : BIT_A;
            end
            default: state_d = IDLE;  // STOP
          endcase
        end
      end
      default: state_d = IDLE;  // illegal encoding
    endcase
  end

  // Output logic: registered outputs are derived from the upcoming state so
  // TXD/RDY change exactly on slot boundaries.
  assign next_bit = msb_first_d ? sr_d[pMSG_LEN-1] : sr_d[0];

  always_comb begin
    done_d = (state_q == STOP) && tmr_exp && !enc.ABORT;
    rdy_d  = (state_d == IDLE);
    case (state_d)
      PRE_LO:  txd_d = 1'b0;
      PRE_HI:  txd_d = 1'b1;
      BIT_A:   txd_d = slot_level(next_bit, pol_d, 1'b0);
      BIT_B:   txd_d = slot_level(next_bit, pol_d, 1'b1);
      default: txd_d = cTXD_IDLE;
    endcase
  end

  assign enc.TXD  = txd_q;
  assign enc.RDY  = rdy_q;
  assign enc.BUSY = ~rdy_q;
  assign enc.DONE = done_q;
endmodule
`default_nettype wire

// File: doc/mcht_enc_gen.md
Name: mcht_enc_gen

Overview:
Parametrised Manchester frame encoder, successor to the fixed 16-bit encoder. Adds:
- configurable half-bit duration
- configurable preamble length
- runtime frame length
- selectable bit order and encoding polarity
- valid/ready start handshake
- abort
Sits between the control FSM that builds messages and the TXD pad driver in the CLK_25M domain.

Parameters:
pMSG_LEN, 16, maximum message bits (2..64)
pHALF_CYC, 1, CLK_25M cycles per half-bit slot (1..256)
pPRE_LEN, 1, preamble pairs (low,high) sent before data (1..8)

Ports:
CLK_25M  in  1  system clock
RST_N  in  1  reset; asynchronous, active-low
START  in  1  frame request (valid)
RDY  out  1  encoder idle, START accepted when START&RDY
MSG  in  pMSG_LEN  message, captured only at accept
LEN  in  $clog2(pMSG_LEN+1)  bits to send, captured at accept; 0 or >pMSG_LEN is treated as pMSG_LEN
MSB_FIRST  in  1  captured at accept; 0 = bit 0 first (legacy order), 1 = bit LEN-1 first
POL  in  1  captured at accept; 0 = bit b sent as (~b, b) (legacy), 1 = (b, ~b)
ABORT  in  1  terminate frame
BUSY  out  1  frame in progress (= ~RDY)
DONE  out  1  one-cycle pulse at frame completion
TXD  out  1  Manchester line, idle high

Behaviour:
- Reset values: TXD=1, RDY=1, BUSY=0, DONE=0. State is IDLE, counters are 0, and the shift register is 0.
- Reset mid-frame: outputs return to their reset values immediately (asynchronous). No DONE is issued.
- Accept edge T:
  - Captures MSG, LEN (after clamp), MSB_FIRST and POL.
  - RDY=0 from T+1.
  - START while RDY=0 is ignored.
  - MSG/LEN/POL changes after T have no effect on the frame.
- Slot timing (all outputs registered):
  - Slot k occupies cycles T+1+k*H .. T+(k+1)*H, where H = pHALF_CYC.
  - TXD changes only on slot boundaries.
- Slot sequence:
  - 2*pPRE_LEN preamble slots alternating 0,1.
  - 2*L data slots, two per bit, in order per MSB_FIRST, levels per POL.
  - 1 stop slot, TXD=1.
- Completion, at cycle Tend = T+1+(2*pPRE_LEN+2*L+1)*H:
  - DONE=1 for exactly that cycle.
  - RDY=1 from that cycle.
  - TXD stays 1.
- Back-to-back: START sampled high at Tend is accepted, so the next frame's first slot begins at Tend+1.
- FSM states and transitions:
  - IDLE: START → PRE_LO
  - PRE_LO → PRE_HI
  - PRE_HI: → PRE_LO while pairs remain, else → BIT_A
  - BIT_A → BIT_B
  - BIT_B: → BIT_A while bits remain, else → STOP
  - STOP → IDLE, pulsing DONE
  - Every non-IDLE state advances only when the half-bit timer expires (timer = H-1).
- Counters:
  - Half-bit timer: $clog2(pHALF_CYC) bits, minimum 1. Reloads to 0 on every slot change. With H=1 it expires every cycle.
  - Bit counter: $clog2(pMSG_LEN+1) bits. Counts down from L; decrements in BIT_B; the last bit is counter==1.
  - Preamble counter counts pairs in the same way.
- Shift register: pMSG_LEN bits, loaded at accept.
  - MSB_FIRST=0: shift right, sending bit 0.
  - MSB_FIRST=1: left-justify the message at load so that bit L-1 sits in the MSB, then shift left, sending the MSB.
- ABORT:
  - Sampled high in any non-IDLE state → IDLE on the next edge, TXD=1, RDY=1, no DONE.
  - In IDLE, ABORT is ignored.
  - ABORT with START in IDLE → START wins.
- Illegal state encoding → IDLE, TXD=1.

Decomposition:
- Package mcht_pkg:
  - state enum t_mcht_st (IDLE, PRE_LO, PRE_HI, BIT_A, BIT_B, STOP)
  - POL constants cPOL_LEGACY=0 and cPOL_IEEE=1
  - idle line level cTXD_IDLE=1
- Sub-module mcht_half_tmr: half-bit slot timer with a clear input and an expire output, parametrised by pHALF_CYC. Reused by the planned decoder.

Test Plan:
- H=1, P=1, LEN=4, MSG=0xA, MSB_FIRST=0, POL=0, accept at T → TXD from T+1 = 0,1,1,0,0,1,1,0,0,1,1; DONE pulse at T+12 only; RDY=1 from T+12.
- H=3, same frame → each level held 3 cycles, edges at T+1+3k; DONE at T+34.
- MSB_FIRST=1, POL=1, LEN=3, MSG=0b110 → data slots 1,0,1,0,0,1; DONE at T+10. LEN=0 with pMSG_LEN=16 → 32 data slots, DONE at T+36.
- Handshake:
  - START held high continuously → frames back-to-back, second accept at Tend, no idle gap beyond the stop slot.
  - MSG toggled mid-frame → transmitted bits unchanged.
  - START pulses while BUSY → ignored.
- ABORT at T+5 (H=1) → TXD=1 from T+6, RDY=1 at T+6, DONE never asserted; a new START at T+6 produces a clean frame.
- RST_N low mid-frame → TXD=1, RDY=1, DONE=0 asynchronously; after release a frame completes normally.
